// File: rtl/m_definitions.sv
`default_nettype none
// ============================================================================
// m_definitions : shared mux encodings, op and state enums for the divider
// Rev 1.0
// ============================================================================
package m_definitions;

   localparam int MUX_R_LENGTH = 2;
   localparam int MUX_D_LENGTH = 2;
   localparam int MUX_Z_LENGTH = 2;

   localparam logic [MUX_R_LENGTH-1:0] MUX_R_KEEP     = 2'd0;
   localparam logic [MUX_R_LENGTH-1:0] MUX_R_A        = 2'd1;
   localparam logic [MUX_R_LENGTH-1:0] MUX_R_A_NEG    = 2'd2;
   localparam logic [MUX_R_LENGTH-1:0] MUX_R_SUB_KEEP = 2'd3;

   localparam logic [MUX_D_LENGTH-1:0] MUX_D_KEEP  = 2'd0;
   localparam logic [MUX_D_LENGTH-1:0] MUX_D_B     = 2'd1;
   localparam logic [MUX_D_LENGTH-1:0] MUX_D_B_NEG = 2'd2;
   localparam logic [MUX_D_LENGTH-1:0] MUX_D_SHR   = 2'd3;

   localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_KEEP    = 2'd0;
   localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_ZERO    = 2'd1;
   localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_SHL_ADD = 2'd2;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ITER = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_ITER = S_ITER,
      ST_DONE = S_DONE
   } div_state_e;

   // Signed variants are the ones with op bit 0 clear.
   function automatic logic is_signed_op(input div_op_e op);
      return !op[0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/m_div_control_if.sv
`default_nettype none
// ============================================================================
// m_div_control_if : handshake and mux-select bundle between core and divider
// Rev 1.0
// ============================================================================
interface m_div_control_if;
   import m_definitions::*;

   logic                    start;
   logic [1:0]              op;
   logic                    rs1_sign;
   logic                    rs2_sign;
   logic                    rs2_zero;
   logic                    flush;
   logic                    sub_neg;
   logic [MUX_R_LENGTH-1:0] mux_R;
   logic [MUX_D_LENGTH-1:0] mux_D;
   logic [MUX_Z_LENGTH-1:0] mux_Z;
   logic                    busy;
   logic                    done;
   logic                    result_sel;
   logic                    negate_result;

   modport master (
      output start, op, rs1_sign, rs2_sign, rs2_zero, flush, sub_neg,
      input  mux_R, mux_D, mux_Z, busy, done, result_sel, negate_result
   );

   modport slave (
      input  start, op, rs1_sign, rs2_sign, rs2_zero, flush, sub_neg,
      output mux_R, mux_D, mux_Z, busy, done, result_sel, negate_result
   );

endinterface
`default_nettype wire

// File: rtl/m_div_control.sv
`default_nettype none
// ============================================================================
// m_div_control : sequencer for a 32-iteration radix-2 divide/remainder unit
// Rev 1.0
// ============================================================================
module m_div_control
   import m_definitions::*;
(
   input  logic           clk,
   input  logic           resetn,
   m_div_control_if.slave bus
);

   div_state_e r_state;
   logic [4:0] r_count;
   div_op_e    r_op;
   logic       r_rs1_sign;
   logic       r_rs2_sign;
   logic       r_rs2_zero;

   logic       w_accept;
   logic       w_last;
   logic       w_unused_sub_neg;

   // sub_neg steers the datapath only; the sequence length is fixed.
   assign w_unused_sub_neg = bus.sub_neg;
   assign w_accept         = (r_state == ST_IDLE) && bus.start && !bus.flush;
   assign w_last           = (r_count == 5'd31);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= ST_IDLE;
         r_count    <= 5'd0;
         r_op       <= OP_DIV;
         r_rs1_sign <= 1'b0;
         r_rs2_sign <= 1'b0;
         r_rs2_zero <= 1'b0;
      end else if (bus.flush) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state    <= ST_ITER;
                  r_count    <= 5'd0;
                  r_op       <= div_op_e'(bus.op);
                  r_rs1_sign <= bus.rs1_sign;
                  r_rs2_sign <= bus.rs2_sign;
                  r_rs2_zero <= bus.rs2_zero;
               end
            end
            ST_ITER: begin
               if (w_last) begin
                  r_state <= ST_DONE;
               end else begin
                  r_count <= r_count + 5'd1;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Reset and flush both force every select back to KEEP in the same cycle.
   always_comb begin
      bus.mux_R = MUX_R_KEEP;
      bus.mux_D = MUX_D_KEEP;
      bus.mux_Z = MUX_Z_KEEP;
      bus.done  = 1'b0;
      if (resetn && !bus.flush) begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  bus.mux_R = (is_signed_op(div_op_e'(bus.op)) && bus.rs1_sign) ? MUX_R_A_NEG : MUX_R_A;
                  bus.mux_D = (is_signed_op(div_op_e'(bus.op)) && bus.rs2_sign) ? MUX_D_B_NEG : MUX_D_B;
                  bus.mux_Z = MUX_Z_ZERO;
               end
            end
            ST_ITER: begin
               bus.mux_R = MUX_R_SUB_KEEP;
               bus.mux_D = MUX_D_SHR;
               bus.mux_Z = MUX_Z_SHL_ADD;
            end
            ST_DONE: bus.done = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.negate_result = 1'b0;
      case (r_op)
         OP_DIV:  bus.negate_result = (r_rs1_sign ^ r_rs2_sign) & ~r_rs2_zero;
         OP_REM:  bus.negate_result = r_rs1_sign;
         default: ;
      endcase
   end

   assign bus.busy       = (r_state != ST_IDLE);
   assign bus.result_sel = r_op[1];

endmodule
`default_nettype wire

// File: tb/tb_m_div_control.sv
`default_nettype none
// ============================================================================
// tb_m_div_control : directed and randomized checks of the divider sequencer
// Rev 1.0
// ============================================================================
module tb_m_div_control;
   import m_definitions::*;

   logic clk = 1'b0;
   logic resetn;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   m_div_control_if bus ();

   m_div_control dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Architectural result of the operation.
   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         2'b00:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
         2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         2'b10:   return (b == 0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Unsigned value the datapath holds before the output negation stage.
   function automatic logic [31:0] mag_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ma, mb;
      ma = (!op[0] && a[31]) ? -a : a;
      mb = (!op[0] && b[31]) ? -b : b;
      if (mb == 0) return op[1] ? ma : 32'hFFFF_FFFF;
      return op[1] ? ma % mb : ma / mb;
   endfunction

   task automatic drive(input logic st, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
      bus.start    = st;
      bus.op       = op;
      bus.rs1_sign = a[31];
      bus.rs2_sign = b[31];
      bus.rs2_zero = (b == 32'd0);
      bus.flush    = fl;
      bus.sub_neg  = 1'($urandom);
   endtask

   task automatic drive_idle();
      drive(1'b0, 2'($urandom), $urandom, $urandom, 1'b0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_keep(input string tag);
      chk({tag, "_mux_R"}, 32'(bus.mux_R), 32'(MUX_R_KEEP));
      chk({tag, "_mux_D"}, 32'(bus.mux_D), 32'(MUX_D_KEEP));
      chk({tag, "_mux_Z"}, 32'(bus.mux_Z), 32'(MUX_Z_KEEP));
   endtask

   // inject: 0 none, 1 random extra starts, 2 extra start every busy cycle.
   // flush_at: ITER cycle (1..32) where flush is raised, 0 for none.
   // exp_neg: exact negate_result required at done, -1 to skip.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inject, input int flush_at, input int exp_neg);
      logic [31:0] mag, obs;
      logic [1:0]  er, ed;
      drive(1'b1, op, a, b, 1'b0);
      @(negedge clk);
      er = (!op[0] && a[31]) ? MUX_R_A_NEG : MUX_R_A;
      ed = (!op[0] && b[31]) ? MUX_D_B_NEG : MUX_D_B;
      chk("start_mux_R", 32'(bus.mux_R), 32'(er));
      chk("start_mux_D", 32'(bus.mux_D), 32'(ed));
      chk("start_mux_Z", 32'(bus.mux_Z), 32'(MUX_Z_ZERO));
      chk("start_busy", 32'(bus.busy), 32'd0);
      next_cycle();
      for (int c = 1; c <= 33; c++) begin
         if (inject == 2 || (inject == 1 && $urandom_range(0, 3) == 0))
            drive(1'b1, 2'($urandom), $urandom, $urandom, 1'b0);
         else
            drive(1'b0, 2'($urandom), $urandom, $urandom, c == flush_at);
         @(negedge clk);
         if (c == flush_at) begin
            chk("flush_done", 32'(bus.done), 32'd0);
            check_keep("flush");
            next_cycle();
            drive_idle();
            @(negedge clk);
            chk("flush_idle_busy", 32'(bus.busy), 32'd0);
            for (int k = 0; k < 36; k++) begin
               next_cycle();
               drive_idle();
               @(negedge clk);
               chk("flush_no_done", 32'(bus.done), 32'd0);
            end
            next_cycle();
            return;
         end else if (c <= 32) begin
            chk("iter_busy", 32'(bus.busy), 32'd1);
            chk("iter_done", 32'(bus.done), 32'd0);
            chk("iter_mux_R", 32'(bus.mux_R), 32'(MUX_R_SUB_KEEP));
            chk("iter_mux_D", 32'(bus.mux_D), 32'(MUX_D_SHR));
            chk("iter_mux_Z", 32'(bus.mux_Z), 32'(MUX_Z_SHL_ADD));
         end else begin
            chk("done_pulse", 32'(bus.done), 32'd1);
            chk("done_busy", 32'(bus.busy), 32'd1);
            check_keep("done");
            chk("result_sel", 32'(bus.result_sel), 32'(op[1]));
            mag = mag_result(op, a, b);
            obs = bus.negate_result ? -mag : mag;
            chk("result_value", obs, ref_result(op, a, b));
            if (exp_neg >= 0) chk("negate_exact", 32'(bus.negate_result), 32'(exp_neg));
         end
         next_cycle();
      end
      drive_idle();
      @(negedge clk);
      chk("after_busy", 32'(bus.busy), 32'd0);
      chk("after_done", 32'(bus.done), 32'd0);
      next_cycle();
   endtask

   initial begin
      logic [31:0] a, b;
      logic [1:0]  op;

      resetn = 1'b0;
      drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
      #2;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_result_sel", 32'(bus.result_sel), 32'd0);
      chk("rst_negate", 32'(bus.negate_result), 32'd0);
      check_keep("rst");
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      drive_idle();
      next_cycle();

      run_op(2'b01, 32'd100, 32'd7, 0, 0, 0);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 1);
      run_op(2'b00, 32'd5, 32'd0, 0, 0, 0);
      run_op(2'b10, 32'd5, 32'd0, 0, 0, 0);
      run_op(2'b00, 32'hFFFF_FFFB, 32'd0, 0, 0, 0);
      run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 0, 0, 1);
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1);
      run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 0, 0, 1);
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);

      run_op(2'b00, 32'hFFFF_FFF0, 32'd3, 0, 10, -1);
      run_op(2'b00, 32'hFFFF_FFF0, 32'd3, 0, 0, 1);
      run_op(2'b10, 32'd17, 32'hFFFF_FFFB, 2, 0, 0);

      drive(1'b1, 2'b00, 32'hFFFF_0000, 32'd9, 1'b1);
      @(negedge clk);
      check_keep("flush_start");
      next_cycle();
      drive_idle();
      @(negedge clk);
      chk("flush_start_busy", 32'(bus.busy), 32'd0);
      next_cycle();

      for (int i = 0; i < 24; i++) begin
         op = 2'($urandom);
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 20));
            3: b = -32'($urandom_range(1, 20));
            default: ;
         endcase
         run_op(op, a, b, 1, 0, -1);
      end

      // Asynchronous reset in the middle of an iteration.
      drive(1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
      next_cycle();
      for (int c = 1; c < 15; c++) begin
         drive_idle();
         next_cycle();
      end
      drive(1'b1, 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
      resetn = 1'b0;
      #1;
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_done", 32'(bus.done), 32'd0);
      chk("midrst_result_sel", 32'(bus.result_sel), 32'd0);
      chk("midrst_negate", 32'(bus.negate_result), 32'd0);
      check_keep("midrst");
      next_cycle();
      drive_idle();
      next_cycle();
      resetn = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         chk("postrst_busy", 32'(bus.busy), 32'd0);
         chk("postrst_done", 32'(bus.done), 32'd0);
         next_cycle();
         drive_idle();
      end
      run_op(2'b01, 32'd100, 32'd7, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
